if_fetch_unit: RTL and testbench

- Instruction-fetch stage; the producer side of the IF/ID pipeline register.
- Owns the PC, issues single-outstanding requests to instruction memory, and drives i_instr/i_pc, flush and ifcon into IF/ID.
- Buffers a returned instruction while decode is stalled and discards wrong-path fetches on a taken branch.

---
 rtl/if_fetch_unit.sv | 135 +++++++++++++
 tb/tb_if_fetch_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and runs a single-outstanding handshake with instruction memory.
// It feeds IF/ID, holds a returned word while decode stalls and drops wrong-path returns after a redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        flush,
  output logic        ifcon
);

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_HELD    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;

  assign pc_plus4_s = pc_q + 32'd4;
  assign target_s   = {br_target[31:2], 2'b00};

  // Next-state logic; a taken branch always wins over a stall.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    redir_pc_d  = redir_pc_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          if (br_taken) begin
            pc_d = target_s;
          end else if (stall_in) begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_plus4_s;
            pc_d        = pc_plus4_s;
            state_d     = ST_HELD;
          end else begin
            pc_d = pc_plus4_s;
          end
        end else if (br_taken) begin
          redir_pc_d = target_s;
          state_d    = ST_DISCARD;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HELD: begin
        if (br_taken) begin
          pc_d    = target_s;
          state_d = ST_FETCH;
        end else if (!stall_in) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HELD;
        end
      end
      ST_DISCARD: begin
        // The pending request cannot be cancelled, so wait for it and drop its data.
        if (imem_ready) begin
          pc_d    = br_taken ? target_s : redir_pc_q;
          state_d = ST_FETCH;
        end else if (br_taken) begin
          redir_pc_d = target_s;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= {RESET_PC[31:2], 2'b00};
      buf_instr_q <= 32'h0000_0000;
      buf_pc_q    <= 32'h0000_0000;
      redir_pc_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      redir_pc_q  <= redir_pc_d;
    end
  end

  // Outputs are forced to zero while reset is asserted.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = 32'h0000_0000;
    o_instr   = 32'h0000_0000;
    o_pc      = 32'h0000_0000;
    flush     = 1'b0;
    ifcon     = 1'b0;
    if (!rst) begin
      imem_req  = (state_q != ST_HELD);
      imem_addr = pc_q;
      flush     = br_taken;
      ifcon     = stall_in & ~br_taken;
      if (state_q == ST_FETCH && imem_ready && !br_taken) begin
        o_instr = imem_rdata;
        o_pc    = pc_plus4_s;
      end else if (state_q == ST_HELD) begin
        o_instr = buf_instr_q;
        o_pc    = buf_pc_q;
      end else begin
        o_instr = 32'h0000_0000;
        o_pc    = 32'h0000_0000;
      end
    end else begin
      imem_req = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;

  logic        req_a, flush_a, ifcon_a;
  logic [31:0] addr_a, instr_a, pc_a;
  logic        req_b, flush_b, ifcon_b;
  logic [31:0] addr_b, instr_b, pc_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .br_taken(br_taken), .br_target(br_target),
    .imem_req(req_a), .imem_addr(addr_a), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .o_instr(instr_a), .o_pc(pc_a), .flush(flush_a), .ifcon(ifcon_a)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clk(clk), .rst(rst), .stall_in(stall_in), .br_taken(br_taken), .br_target(br_target),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .o_instr(instr_b), .o_pc(pc_b), .flush(flush_b), .ifcon(ifcon_b)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_flush;
    logic        e_ifcon;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, input logic s, input logic b, input logic [31:0] t,
                   input logic rd, input logic [31:0] dat, input logic q, input logic [31:0] a,
                   input logic [31:0] ins, input logic [31:0] p, input logic f, input logic c);
    vec_t x;
    x = '{r, s, b, t, rd, dat, q, a, ins, p, f, c};
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic rd, input logic [31:0] dat);
    @(negedge clk);
    rst = r; stall_in = s; br_taken = b; br_target = t; imem_ready = rd; imem_rdata = dat;
    #1;
  endtask

  initial begin
    //  rst s  b  tgt          rdy rdata          req addr          instr          pc            fl ic
    v(1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,         1'b0,32'h0,       32'h0,         32'h0,        1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b1,32'hA5A5_0000, 1'b1,32'h0,       32'hA5A5_0000, 32'h4,        1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b1,32'hA5A5_0004, 1'b1,32'h4,       32'hA5A5_0004, 32'h8,        1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b0,32'h0,         1'b1,32'h8,       32'h0,         32'h0,        1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b0,32'h0,         1'b1,32'h8,       32'h0,         32'h0,        1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b0,32'h0,         1'b1,32'h8,       32'h0,         32'h0,        1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b1,32'hA5A5_0008, 1'b1,32'h8,       32'hA5A5_0008, 32'hC,        1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b1,32'hA5A5_000C, 1'b1,32'hC,       32'hA5A5_000C, 32'h10,       1'b0,1'b0);
    v(1'b0,1'b1,1'b0,32'h0,    1'b1,32'hA5A5_0010, 1'b1,32'h10,      32'hA5A5_0010, 32'h14,       1'b0,1'b1);
    v(1'b0,1'b1,1'b0,32'h0,    1'b0,32'h0,         1'b0,32'h14,      32'hA5A5_0010, 32'h14,       1'b0,1'b1);
    v(1'b0,1'b0,1'b0,32'h0,    1'b0,32'h0,         1'b0,32'h14,      32'hA5A5_0010, 32'h14,       1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b1,32'hA5A5_0014, 1'b1,32'h14,      32'hA5A5_0014, 32'h18,       1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b1,32'hA5A5_0018, 1'b1,32'h18,      32'hA5A5_0018, 32'h1C,       1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b1,32'hA5A5_001C, 1'b1,32'h1C,      32'hA5A5_001C, 32'h20,       1'b0,1'b0);
    v(1'b0,1'b0,1'b1,32'h103,  1'b0,32'h0,         1'b1,32'h20,      32'h0,         32'h0,        1'b1,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b0,32'h0,         1'b1,32'h20,      32'h0,         32'h0,        1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b1,32'hA5A5_0020, 1'b1,32'h20,      32'h0,         32'h0,        1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b1,32'hA5A5_0100, 1'b1,32'h100,     32'hA5A5_0100, 32'h104,      1'b0,1'b0);
    v(1'b0,1'b1,1'b0,32'h0,    1'b1,32'hA5A5_0104, 1'b1,32'h104,     32'hA5A5_0104, 32'h108,      1'b0,1'b1);
    v(1'b0,1'b1,1'b1,32'h200,  1'b0,32'h0,         1'b0,32'h108,     32'hA5A5_0104, 32'h108,      1'b1,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b1,32'hA5A5_0200, 1'b1,32'h200,     32'hA5A5_0200, 32'h204,      1'b0,1'b0);
    v(1'b0,1'b0,1'b1,32'h300,  1'b1,32'hA5A5_0204, 1'b1,32'h204,     32'h0,         32'h0,        1'b1,1'b0);
    v(1'b0,1'b0,1'b1,32'h400,  1'b0,32'h0,         1'b1,32'h300,     32'h0,         32'h0,        1'b1,1'b0);
    v(1'b0,1'b0,1'b1,32'h500,  1'b0,32'h0,         1'b1,32'h300,     32'h0,         32'h0,        1'b1,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b1,32'hA5A5_0300, 1'b1,32'h300,     32'h0,         32'h0,        1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b1,32'hA5A5_0500, 1'b1,32'h500,     32'hA5A5_0500, 32'h504,      1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b0,32'h0,         1'b1,32'h504,     32'h0,         32'h0,        1'b0,1'b0);
    v(1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,         1'b0,32'h0,       32'h0,         32'h0,        1'b0,1'b0);
    v(1'b0,1'b0,1'b0,32'h0,    1'b1,32'hA5A5_0000, 1'b1,32'h0,       32'hA5A5_0000, 32'h4,        1'b0,1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].rdy, vecs[i].rdata);
      chk("imem_req",  i, {31'd0, req_a},   {31'd0, vecs[i].e_req});
      chk("imem_addr", i, addr_a,           vecs[i].e_addr);
      chk("o_instr",   i, instr_a,          vecs[i].e_instr);
      chk("o_pc",      i, pc_a,             vecs[i].e_pc);
      chk("flush",     i, {31'd0, flush_a}, {31'd0, vecs[i].e_flush});
      chk("ifcon",     i, {31'd0, ifcon_a}, {31'd0, vecs[i].e_ifcon});
    end

    // DISCARD with a returning response and a new branch in the same cycle: newest target wins.
    drive(1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0);
    chk("disc_enter_addr", 100, addr_a, 32'h4);
    drive(1'b0, 1'b0, 1'b1, 32'h702, 1'b1, 32'hA5A5_0004);
    chk("disc_drop_instr", 101, instr_a, 32'h0);
    chk("disc_drop_flush", 101, {31'd0, flush_a}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA5A5_0700);
    chk("disc_redir_addr", 102, addr_a, 32'h700);
    chk("disc_redir_pc",   102, pc_a,   32'h704);

    // High reset vector wraps through zero.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hi_rst_req", 200, {31'd0, req_b}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5A5A_FFF8);
    chk("hi_addr0", 201, addr_b, 32'hFFFF_FFF8);
    chk("hi_pc0",   201, pc_b,   32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5A5A_FFFC);
    chk("hi_addr1", 202, addr_b, 32'hFFFF_FFFC);
    chk("hi_pc1",   202, pc_b,   32'h0000_0000);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hi_addr2", 203, addr_b, 32'h0000_0000);
    chk("hi_req2",  203, {31'd0, req_b}, 32'h1);
    // Reset while the request at 0 is still pending.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hi_midrst_req",  204, {31'd0, req_b}, 32'h0);
    chk("hi_midrst_addr", 204, addr_b, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hi_restart_addr", 205, addr_b, 32'hFFFF_FFF8);
    chk("hi_restart_req",  205, {31'd0, req_b}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
